coin_accumulator: RTL and testbench
===================================

Name: coin_accumulator

Overview:
Consumer of the one-cycle debounced key pulses produced by the team's key debouncer instances in the seller design.
- Accumulates coin credit from two coin keys (0.5 and 1.0 units).
- Drives a timed vend strobe once credit reaches the price.
- Reports change, or a full refund on cancel.
- Sits between the per-key debouncers and the display/actuator logic.

Parameters:
PRICE, 5, item price in half-unit counts (5 = 2.5); legal range 1..29.
DISPENSE_CYC, 50_000_000, cycles vend stays high (1 s at 50 MHz); must be >= 1.
TIMEOUT_CYC, 1_500_000_000, idle cycles in ACCUM before auto-refund (used only with CREDIT_TIMEOUT_EN).

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
coin_half  input  1  one-cycle pulse from debouncer, +1 half-unit
coin_one  input  1  one-cycle pulse from debouncer, +2 half-units
cancel  input  1  one-cycle pulse from debouncer, refund request
credit  output  5  current credit in half-units, registered
vend  output  1  high for exactly DISPENSE_CYC cycles per sale
change  output  5  change/refund amount in half-units, held until next change_valid
change_valid  output  1  one-cycle strobe; change is valid in that cycle
coin_reject  output  1  one-cycle strobe; coin pulse arrived while not accepting
busy  output  1  high in DISPENSE and REFUND

Behaviour:
- Reset (async, rst_n low):
  - Outputs: credit=0, vend=0, change=0, change_valid=0, coin_reject=0, busy=0.
  - Internal: state=IDLE, counters=0.
  - Reset mid-DISPENSE aborts the sale: vend drops immediately and no change is issued.
- Coin value per cycle: add = coin_half*1 + coin_one*2. Simultaneous half+one adds 3.
- Width: credit is 5 bits. Maximum reachable is PRICE-1+3 <= 31, so no overflow logic is needed.
- States: IDLE, ACCUM, DISPENSE, REFUND.
- IDLE/ACCUM, cycle N with add>0 and no cancel:
  - credit <= credit+add at N+1.
  - If credit+add >= PRICE, enter DISPENSE at N+1; otherwise enter/stay ACCUM.
- IDLE/ACCUM with cancel at N:
  - Coins in the same cycle are added first; the sum is refunded.
  - Enter REFUND at N+1, unless the sum is 0 (cancel in IDLE with no coin), which is ignored.
- DISPENSE:
  - vend=1 and busy=1 from N+1 through N+DISPENSE_CYC.
  - At N+DISPENSE_CYC+1: state=IDLE, credit=0, vend=0.
  - change <= credit-PRICE; change_valid=1 for that one cycle only if change>0.
- REFUND (single cycle, busy=1):
  - Next cycle: change <= credit, change_valid=1, credit=0, state=IDLE.
- Coins during DISPENSE/REFUND:
  - Not added; coin_reject=1 the following cycle, once per offending cycle.
  - cancel is ignored.
- Output timing: all outputs are registered, with no combinational input-to-output paths.
- Steady state: credit holds indefinitely in ACCUM without input (see optional feature).

Optional Feature:
Macro: CREDIT_TIMEOUT_EN.
- Defined:
  - ACCUM keeps an idle counter, cleared on every accepted coin.
  - When it reaches TIMEOUT_CYC-1, transition to REFUND, exactly as for a cancel.
  - Counter is inactive outside ACCUM.
- Undefined: no counter logic exists; credit persists until coins or cancel.

Decomposition:
- Package seller_pkg:
  - state enum (IDLE, ACCUM, DISPENSE, REFUND).
  - Constants COIN_HALF_VAL=1, COIN_ONE_VAL=2, CREDIT_W=5.
- Sub-module cycle_timer (load, enable, done pulse at terminal count):
  - Instantiated once for the DISPENSE duration.
  - Instantiated again for the timeout under CREDIT_TIMEOUT_EN.

Test Plan:
- Exact payment, PRICE=5, DISPENSE_CYC=4 (all tests below use these values): pulses one, one, half, spaced 10 cycles -> credit 2, 4, 5; vend high 4 cycles; no change_valid; credit returns to 0.
- Overpay: one, one, one -> credit 6; vend 4 cycles; then change=1 with one change_valid cycle.
- Same-cycle coins: credit 2, then coin_half+coin_one together -> credit 5 next cycle; DISPENSE entered; change=0, no strobe.
- Cancel: half, one, then cancel -> REFUND; change=3, change_valid one cycle, credit=0. Cancel in IDLE -> no response.
- Busy rejection, then reset mid-sale:
  - coin_one pulse during DISPENSE -> coin_reject one cycle; credit/change unaffected.
  - rst_n low during vend -> all outputs 0 immediately; no change_valid after release.
- CREDIT_TIMEOUT_EN defined, TIMEOUT_CYC=20: half, then no input -> REFUND after 20 idle cycles; change=1, change_valid once. Macro undefined -> credit stays 1 for 100 cycles.

Source files
------------

// File: rtl/seller_pkg.sv
// Shared constants and state encoding for the seller datapath.
// Coin values are in half-unit counts, matching the credit register.
package seller_pkg;

   localparam int CREDIT_W      = 5;
   localparam int COIN_HALF_VAL = 1;
   localparam int COIN_ONE_VAL  = 2;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ACCUM    = 2'd1;
   localparam logic [1:0] DISPENSE = 2'd2;
   localparam logic [1:0] REFUND   = 2'd3;

   function automatic logic [CREDIT_W-1:0] coin_value(input logic half, input logic one);
      logic [CREDIT_W-1:0] v;
      v = '0;
      if (half) v = v + CREDIT_W'(COIN_HALF_VAL);
      if (one)  v = v + CREDIT_W'(COIN_ONE_VAL);
      return v;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter cleared by load, advanced by enable; done flags the cycle in
// which the count sits at TERMINAL while enabled. The count saturates there.
module cycle_timer #(
   parameter int W        = 8,
   parameter int TERMINAL = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic done
);

   localparam logic [W-1:0] TERM = W'(TERMINAL);

   logic [W-1:0] cnt;

   assign done = enable && (cnt == TERM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (enable && !done) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/coin_accumulator.sv
// Coin credit accumulator with timed vend strobe and change/refund reporting.
// Optional idle auto-refund in ACCUM is built when CREDIT_TIMEOUT_EN is defined.
module coin_accumulator
   import seller_pkg::*;
#(
   parameter int PRICE        = 5,
   parameter int DISPENSE_CYC = 50_000_000,
   parameter int TIMEOUT_CYC  = 1_500_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_half,
   input  logic                coin_one,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic                vend,
   output logic [CREDIT_W-1:0] change,
   output logic                change_valid,
   output logic                coin_reject,
   output logic                busy
);

   // Both timers share one width, sized for the longer of the two intervals.
   localparam int MAX_CYC = (DISPENSE_CYC > TIMEOUT_CYC) ? DISPENSE_CYC : TIMEOUT_CYC;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);
   localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);

   logic [1:0]          state;
   logic [CREDIT_W-1:0] add;
   logic [CREDIT_W-1:0] sum;
   logic                any_coin;
   logic                disp_done;
   logic                timeout_done;

   assign add      = coin_value(coin_half, coin_one);
   assign sum      = credit + add;
   assign any_coin = coin_half || coin_one;

   cycle_timer #(
      .W        (TMR_W),
      .TERMINAL (DISPENSE_CYC - 1)
   ) u_dispense_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state != DISPENSE),
      .enable (state == DISPENSE),
      .done   (disp_done)
   );

`ifdef CREDIT_TIMEOUT_EN
   // Any accepted coin restarts the idle interval.
   cycle_timer #(
      .W        (TMR_W),
      .TERMINAL (TIMEOUT_CYC - 1)
   ) u_timeout_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   ((state != ACCUM) || any_coin),
      .enable (state == ACCUM),
      .done   (timeout_done)
   );
`else
   assign timeout_done = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         credit       <= '0;
         vend         <= 1'b0;
         change       <= '0;
         change_valid <= 1'b0;
         coin_reject  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         change_valid <= 1'b0;
         coin_reject  <= 1'b0;
         case (state)
            IDLE, ACCUM: begin
               // Same-cycle coins are credited before a cancel refunds them.
               if (cancel && (sum != '0)) begin
                  credit <= sum;
                  state  <= REFUND;
                  busy   <= 1'b1;
               end else if (any_coin) begin
                  credit <= sum;
                  if (sum >= PRICE_V) begin
                     state <= DISPENSE;
                     vend  <= 1'b1;
                     busy  <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end else if (timeout_done) begin
                  state <= REFUND;
                  busy  <= 1'b1;
               end
            end
            DISPENSE: begin
               coin_reject <= any_coin;
               if (disp_done) begin
                  state        <= IDLE;
                  credit       <= '0;
                  vend         <= 1'b0;
                  busy         <= 1'b0;
                  change       <= credit - PRICE_V;
                  change_valid <= (credit != PRICE_V);
               end
            end
            default: begin
               coin_reject  <= any_coin;
               change       <= credit;
               change_valid <= 1'b1;
               credit       <= '0;
               state        <= IDLE;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coin_accumulator.sv
// Scenario bench for coin_accumulator (PRICE=5, DISPENSE_CYC=4, TIMEOUT_CYC=20).
// Expected change values are queued at stimulus time and popped on change_valid.
module tb_coin_accumulator;

   localparam int PRICE    = 5;
   localparam int DISP_CYC = 4;
   localparam int TO_CYC   = 20;
   localparam int W        = 5;

   logic         clk;
   logic         rst_n;
   logic         coin_half;
   logic         coin_one;
   logic         cancel;
   logic [W-1:0] credit;
   logic         vend;
   logic [W-1:0] change;
   logic         change_valid;
   logic         coin_reject;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int vend_run = 0;
   logic [W-1:0] exp_q[$];

   coin_accumulator #(
      .PRICE        (PRICE),
      .DISPENSE_CYC (DISP_CYC),
      .TIMEOUT_CYC  (TO_CYC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_half    (coin_half),
      .coin_one     (coin_one),
      .cancel       (cancel),
      .credit       (credit),
      .vend         (vend),
      .change       (change),
      .change_valid (change_valid),
      .coin_reject  (coin_reject),
      .busy         (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: every change_valid must match the head of exp_q; vend bursts must be DISP_CYC long
   always @(negedge clk) begin
      if (!rst_n) begin
         vend_run = 0;
      end else begin
         if (change_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change_valid: change=%0d, none expected", change);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               if (change !== e) begin
                  errors++;
                  $display("FAIL change_value: got %0d, expected %0d", change, e);
               end
            end
         end
         if (vend) begin
            vend_run++;
         end else if (vend_run != 0) begin
            checks++;
            if (vend_run != DISP_CYC) begin
               errors++;
               $display("FAIL vend_length: got %0d cycles, expected %0d", vend_run, DISP_CYC);
            end
            vend_run = 0;
         end
      end
   end

   // driver tasks
   task automatic pulse(input logic h, input logic o, input logic c);
      @(negedge clk);
      coin_half = h;
      coin_one  = o;
      cancel    = c;
      @(negedge clk);
      coin_half = 1'b0;
      coin_one  = 1'b0;
      cancel    = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!busy && !vend) break;
      end
      checks++;
      if (k == 50) begin
         errors++;
         $display("FAIL %s_idle_timeout: busy=%0b vend=%0b after 50 cycles", name, busy, vend);
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending_change: %0d expected change strobes missing", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // scenarios
   task automatic test_reset();
      rst_n = 1'b0;
      idle_cycles(2);
      checks++;
      if ({credit, vend, change, change_valid, coin_reject, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: credit=%0d vend=%0b change=%0d cv=%0b rej=%0b busy=%0b, expected all 0",
                  credit, vend, change, change_valid, coin_reject, busy);
      end
      rst_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_exact();
      pulse(1'b0, 1'b1, 1'b0);
      chk("exact_credit_2", credit, 5'd2);
      idle_cycles(10);
      pulse(1'b0, 1'b1, 1'b0);
      chk("exact_credit_4", credit, 5'd4);
      idle_cycles(10);
      pulse(1'b1, 1'b0, 1'b0);
      chk("exact_credit_5", credit, 5'd5);
      chk("exact_vend_on", {4'd0, vend}, 5'd1);
      chk("exact_busy_on", {4'd0, busy}, 5'd1);
      wait_idle("exact");
      chk("exact_credit_cleared", credit, 5'd0);
   endtask

   task automatic test_overpay();
      pulse(1'b0, 1'b1, 1'b0);
      idle_cycles($urandom_range(1, 8));
      pulse(1'b0, 1'b1, 1'b0);
      idle_cycles($urandom_range(1, 8));
      exp_q.push_back(5'd1);
      pulse(1'b0, 1'b1, 1'b0);
      chk("overpay_credit_6", credit, 5'd6);
      wait_idle("overpay");
      chk("overpay_change_held", change, 5'd1);
   endtask

   task automatic test_same_cycle();
      pulse(1'b0, 1'b1, 1'b0);
      chk("same_credit_2", credit, 5'd2);
      pulse(1'b1, 1'b1, 1'b0);
      chk("same_credit_5", credit, 5'd5);
      chk("same_vend_on", {4'd0, vend}, 5'd1);
      wait_idle("same");
      chk("same_change_zero", change, 5'd0);
   endtask

   task automatic test_cancel();
      pulse(1'b1, 1'b0, 1'b0);
      idle_cycles($urandom_range(1, 8));
      pulse(1'b0, 1'b1, 1'b0);
      chk("cancel_credit_3", credit, 5'd3);
      exp_q.push_back(5'd3);
      pulse(1'b0, 1'b0, 1'b1);
      chk("cancel_busy_refund", {4'd0, busy}, 5'd1);
      wait_idle("cancel");
      chk("cancel_credit_cleared", credit, 5'd0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("cancel_idle_busy", {4'd0, busy}, 5'd0);
      idle_cycles(5);
      chk("cancel_idle_credit", credit, 5'd0);
   endtask

   task automatic test_reject_and_reset();
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      chk("reject_vend_on", {4'd0, vend}, 5'd1);
      pulse(1'b0, 1'b1, 1'b0);
      chk("reject_strobe", {4'd0, coin_reject}, 5'd1);
      chk("reject_credit_kept", credit, 5'd5);
      chk("reject_change_kept", change, 5'd3);
      @(negedge clk);
      chk("reject_strobe_single", {4'd0, coin_reject}, 5'd0);
      chk("reject_vend_still_on", {4'd0, vend}, 5'd1);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({credit, vend, change, change_valid, coin_reject, busy} !== '0) begin
         errors++;
         $display("FAIL midsale_reset: credit=%0d vend=%0b change=%0d cv=%0b rej=%0b busy=%0b, expected all 0",
                  credit, vend, change, change_valid, coin_reject, busy);
      end
      idle_cycles(2);
      rst_n = 1'b1;
      idle_cycles(10);
      chk("midsale_post_credit", credit, 5'd0);
      chk("midsale_post_vend", {4'd0, vend}, 5'd0);
   endtask

   task automatic test_timeout();
      pulse(1'b1, 1'b0, 1'b0);
      chk("timeout_credit_1", credit, 5'd1);
`ifdef CREDIT_TIMEOUT_EN
      begin
         int k;
         exp_q.push_back(5'd1);
         for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) break;
         end
         chk("timeout_refund_delay", W'(k), W'(TO_CYC));
         wait_idle("timeout");
         chk("timeout_credit_cleared", credit, 5'd0);
      end
`else
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (credit !== 5'd1 || busy) bad++;
         end
         chk("timeout_credit_persists_bad_cycles", W'(bad), 5'd0);
         exp_q.push_back(5'd1);
         pulse(1'b0, 1'b0, 1'b1);
         wait_idle("persist_cleanup");
      end
`endif
   endtask

   initial begin
      coin_half = 1'b0;
      coin_one  = 1'b0;
      cancel    = 1'b0;
      rst_n     = 1'b0;
      test_reset();
      test_exact();
      test_overpay();
      test_same_cycle();
      test_cancel();
      test_reject_and_reset();
      test_timeout();
      idle_cycles(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: %0d expected change strobes never seen", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
